// File: rtl/cdc_hs_rx.sv
// Receive side of a toggle req/ack CDC handshake with a valid/ready output.
// Optional overrun detection: define CDC_HS_RX_OVERRUN_DET_EN.
module cdc_hs_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              ack_tgl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   seen_q, seen_d;
    logic                   ack_q, ack_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic req_sync;
    logic new_req;
    logic capture;
    logic accept;

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign new_req  = req_sync ^ seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl_async};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (new_req)   state_d = VALID;
            VALID:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == VALID);
        capture   = (state_q == IDLE) && new_req;
        accept    = (state_q == VALID) && out_ready;
    end

    // Source holds data_async stable until it sees ack, so capture is safe.
    always_comb begin
        seen_d = seen_q;
        data_d = data_q;
        ack_d  = ack_q;
        cnt_d  = cnt_q;
        if (capture) begin
            seen_d = req_sync;
            data_d = data_async;
        end
        if (accept) begin
            ack_d = ~ack_q;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
            data_q <= '0;
            ack_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            seen_q <= seen_d;
            data_q <= data_d;
            ack_q  <= ack_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ack_tgl  = ack_q;
    assign out_data = data_q;
    assign xfer_cnt = cnt_q;

`ifdef CDC_HS_RX_OVERRUN_DET_EN
    logic ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if ((state_q == VALID) && new_req) begin
            ovr_q <= 1'b1;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Randomised bench for cdc_hs_rx against a queue-based transfer model.
// Build with CDC_HS_RX_OVERRUN_DET_EN to exercise overrun detection.
module tb_cdc_hs_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_tgl_async = 1'b0;
    logic [7:0] data_async = 8'h00;
    logic       ack_tgl;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [15:0] xfer_cnt;
    logic       overrun;

    logic       ack4;
    logic       valid4;
    logic [7:0] data4;
    logic [3:0] cnt4;
    logic       ovr4;

`ifdef CDC_HS_RX_OVERRUN_DET_EN
    localparam int OVR_EXP = 1;
`else
    localparam int OVR_EXP = 0;
`endif

    int errs = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [7:0] exp_q[$];
    logic mon_en = 1'b1;

    always #5 clk = ~clk;

    cdc_hs_rx dut (
        .clk(clk), .rst(rst),
        .req_tgl_async(req_tgl_async), .data_async(data_async),
        .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt), .overrun(overrun)
    );

    // Narrow counter copy: exercises the wrap many times in one run.
    cdc_hs_rx #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_tgl_async(req_tgl_async), .data_async(data_async),
        .ack_tgl(ack4), .out_valid(valid4), .out_data(data4),
        .out_ready(out_ready), .xfer_cnt(cnt4), .overrun(ovr4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        data_async    = d;
        req_tgl_async = ~req_tgl_async;
        exp_q.push_back(d);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    // Model: words leave in send order, one per valid&ready, counter wraps.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (mon_en) begin
            check("cnt", 32'(xfer_cnt), 32'(exp_cnt % 65536));
            check("cnt4", 32'(cnt4), 32'(exp_cnt % 16));
            check("ack", 32'(ack_tgl), 32'(exp_cnt % 2));
            check("ack4", 32'(ack4), 32'(exp_cnt % 2));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        int sent;
        logic last_ack;

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ack", 32'(ack_tgl), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 2: single word, ready already high, latency
        out_ready = 1'b1;
        send(8'hA5);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("t2_lat", 32'(lat), 32'd3);
        check("t2_data", 32'(out_data), 32'hA5);
        @(negedge clk);
        check("t2_valid_drop", 32'(out_valid), 32'd0);
        check("t2_ack", 32'(ack_tgl), 32'd1);
        check("t2_cnt", 32'(xfer_cnt), 32'd1);

        // 3: backpressure hold
        tick();
        out_ready = 1'b0;
        send(8'h3C);
        wait_valid("t3_valid_to");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'h3C);
            check("t3_hold_ack", 32'(ack_tgl), 32'd1);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_valid_drop", 32'(out_valid), 32'd0);
        check("t3_ack", 32'(ack_tgl), 32'd0);
        check("t3_cnt", 32'(xfer_cnt), 32'd2);

        // 4: 100 words, source flips req on each ack, random ready
        tick();
        sent = 0;
        last_ack = ack_tgl;
        send(8'(sent));
        sent++;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            if (ack_tgl != last_ack && sent < 100) begin
                last_ack = ack_tgl;
                send(8'(sent));
                sent++;
            end
            if (sent == 100 && exp_q.size() == 0) break;
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_sent", 32'(sent), 32'd100);
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        check("t4_cnt", 32'(xfer_cnt), 32'd102);
        check("t4_cnt4", 32'(cnt4), 32'd6);

        // 5: second flip while valid
        tick();
        send(8'h11);
        wait_valid("t5_valid_to");
        tick();
        send(8'h22);
        repeat (4) tick();
        @(negedge clk);
        check("t5_ovr_set", 32'(overrun), 32'(OVR_EXP));
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        out_ready = 1'b0;
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("t5_ovr_sticky", 32'(overrun), 32'(OVR_EXP));
        check("t5_cnt", 32'(xfer_cnt), 32'd104);

        // 6: reset while valid
        tick();
        send(8'h5A);
        wait_valid("t6_valid_to");
        tick();
        rst = 1'b1;
        req_tgl_async = 1'b0;
        data_async = 8'h00;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_ack", 32'(ack_tgl), 32'd0);
        check("t6_cnt", 32'(xfer_cnt), 32'd0);
        check("t6_ovr", 32'(overrun), 32'd0);
        repeat (5) tick();
        @(negedge clk);
        check("t6_quiet", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
